// File: rtl/byte_packer.sv
// byte_packer: per-lane byte-to-word packer, MSB-first, with a two-stage
// (assembly + output) register pair per lane and an optional partial-word flush.
//
// Ports (lane c):
//   clk, rst_n     clock, asynchronous active-low reset
//   in_data        byte for lane c at [8c+7:8c]
//   in_valid       byte present on lane c
//   in_ready       lane c can accept a byte (combinational from out_ready)
//   flush          request to emit lane c's partial word
//   out_data       packed word for lane c at [W(c+1)-1:Wc], W = BYTES_PER_WORD*8
//   out_cnt        valid bytes in lane c's output word, 4 bits per lane
//   out_valid      lane c output register holds a word
//   out_ready      consumer takes lane c's word
//   ovf            sticky: lane c dropped a byte (DROP_ON_FULL = 1 only)
module byte_packer #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned DROP_ON_FULL   = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CHANNELS*8-1:0]                in_data,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    input  logic [CHANNELS-1:0]                  flush,
    output logic [CHANNELS*BYTES_PER_WORD*8-1:0] out_data,
    output logic [CHANNELS*4-1:0]                out_cnt,
    output logic [CHANNELS-1:0]                  out_valid,
    input  logic [CHANNELS-1:0]                  out_ready,
    output logic [CHANNELS-1:0]                  ovf
);

    localparam int unsigned W  = BYTES_PER_WORD * 8;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);
    localparam logic [CW-1:0] FULL = CW'(BYTES_PER_WORD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
        logic [W-1:0]  asm_q, asm_d, asm_ins;
        logic [W-1:0]  odata_q, odata_d;
        logic [CW-1:0] ocnt_q, ocnt_d;
        logic          ovalid_q, ovalid_d;
        logic          pend_q, pend_d;
        logic          ovf_q, ovf_d;
        logic          out_free, ready_int, accept, flush_req;

        // Next-state for one lane: byte insert, then full-word or flush emit.
        always_comb begin
            out_free  = !ovalid_q || out_ready[c];
            ready_int = ((cnt_q < LAST) || out_free) && !pend_q;
            accept    = in_valid[c] && ready_int;
            flush_req = flush[c] || pend_q;
            cnt_inc   = accept ? cnt_q + CW'(1) : cnt_q;

            // Counter selects the byte slot; data value never implies emptiness.
            asm_ins = asm_q;
            for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
                if (accept && (cnt_q == CW'(b))) begin
                    asm_ins[(BYTES_PER_WORD-1-b)*8 +: 8] = in_data[c*8 +: 8];
                end
            end

            cnt_d    = cnt_inc;
            asm_d    = asm_ins;
            odata_d  = odata_q;
            ocnt_d   = ocnt_q;
            ovalid_d = ovalid_q && !out_ready[c];
            pend_d   = pend_q;
            ovf_d    = ovf_q;

            if ((DROP_ON_FULL != 0) && in_valid[c] && !ready_int) begin
                ovf_d = 1'b1;
            end

            // A completing byte can only be accepted when the output is free.
            if (cnt_inc == FULL) begin
                odata_d  = asm_ins;
                ocnt_d   = FULL;
                ovalid_d = 1'b1;
                cnt_d    = '0;
                asm_d    = '0;
                pend_d   = 1'b0;
            end else if (flush_req) begin
                if (cnt_inc == '0) begin
                    pend_d = 1'b0;
                end else if (out_free) begin
                    // Assembly register is cleared on every emit, so unused low bytes are zero.
                    odata_d  = asm_ins;
                    ocnt_d   = cnt_inc;
                    ovalid_d = 1'b1;
                    cnt_d    = '0;
                    asm_d    = '0;
                    pend_d   = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end
        end

        // Lane state registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                asm_q    <= '0;
                odata_q  <= '0;
                ocnt_q   <= '0;
                ovalid_q <= 1'b0;
                pend_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                asm_q    <= asm_d;
                odata_q  <= odata_d;
                ocnt_q   <= ocnt_d;
                ovalid_q <= ovalid_d;
                pend_q   <= pend_d;
                ovf_q    <= ovf_d;
            end
        end

        assign in_ready[c]          = (DROP_ON_FULL != 0) ? 1'b1 : ready_int;
        assign out_data[c*W +: W]   = odata_q;
        assign out_cnt[c*4 +: 4]    = ocnt_q;
        assign out_valid[c]         = ovalid_q;
        assign ovf[c]               = ovf_q;
    end

endmodule
